// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - interrupt entry sequencer: RES/NMI/BRK/IRQ arbitration, stack push and vector fetch steps
module irq_sched #(
  parameter logic [7:0] VEC_HI = 8'hFF
) (
  input  logic        CLK,
  input  logic        n_RES,
  input  logic        n_NMI,
  input  logic        n_IRQ,
  input  logic        I_FLAG,
  input  logic        BRK,
  input  logic        SYNC,
  input  logic        RDY,
  output logic        BUSY,
  output logic [2:0]  STEP,
  output logic        PUSH,
  output logic [1:0]  PUSH_SEL,
  output logic        B_OUT,
  output logic        SET_I,
  output logic        VEC_RD,
  output logic [15:0] VEC_ADDR,
  output logic        NMI_PEND,
  output logic        DONE
);

  // Step states are encoded so that their value equals the STEP output.
  typedef enum logic [2:0] {
    ST_S0   = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_S6   = 3'd6,
    ST_IDLE = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_NMI = 2'd1,
    SRC_BRK = 2'd2,
    SRC_IRQ = 2'd3
  } src_e;

  localparam logic [7:0] VEC_LO_NMI = 8'hFA;
  localparam logic [7:0] VEC_LO_RES = 8'hFC;
  localparam logic [7:0] VEC_LO_IRQ = 8'hFE;

  state_e     state_q, state_d;
  src_e       src_q, src_d;
  logic [7:0] vec_lo_q, vec_lo_d;
  logic       res_pend_q, res_pend_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_r_q;
  logic       nmi_arm_q;
  logic       done_q, done_d;

  logic       busy;
  logic       nmi_fall;
  logic       nmi_clr;
  logic [7:0] lock_vec;

  assign busy = (state_q != ST_IDLE);

  // The arm flag masks the first sample after reset, so a line held low
  // through reset is not mistaken for a falling edge.
  assign nmi_fall = nmi_arm_q & nmi_r_q & ~n_NMI;

  // Vector chosen when entering step 5; a pending NMI hijacks BRK/IRQ.
  always_comb begin
    lock_vec = VEC_LO_IRQ;
    case (src_q)
      SRC_RES: lock_vec = VEC_LO_RES;
      SRC_NMI: lock_vec = VEC_LO_NMI;
      default: lock_vec = nmi_pend_q ? VEC_LO_NMI : VEC_LO_IRQ;
    endcase
  end

  // NMI line sampler, runs every cycle independent of RDY.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      nmi_r_q   <= 1'b1;
      nmi_arm_q <= 1'b0;
    end else begin
      nmi_r_q   <= n_NMI;
      nmi_arm_q <= 1'b1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_RES;
      vec_lo_q   <= 8'h00;
      res_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      vec_lo_q   <= vec_lo_d;
      res_pend_q <= res_pend_d;
      nmi_pend_q <= nmi_pend_d;
      done_q     <= done_d;
    end
  end

  // Next-state: arbitration at the instruction boundary, then step walk.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    vec_lo_d   = vec_lo_q;
    res_pend_d = res_pend_q;
    done_d     = 1'b0;
    nmi_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (SYNC && RDY) begin
          if (res_pend_q) begin
            src_d   = SRC_RES;
            state_d = ST_S0;
          end else if (nmi_pend_q) begin
            src_d   = SRC_NMI;
            state_d = ST_S0;
          end else if (BRK) begin
            src_d   = SRC_BRK;
            state_d = ST_S0;
          end else if (!n_IRQ && !I_FLAG) begin
            src_d   = SRC_IRQ;
            state_d = ST_S0;
          end
        end
      end
      ST_S0: if (RDY) state_d = ST_S1;
      ST_S1: if (RDY) state_d = ST_S2;
      ST_S2: if (RDY) state_d = ST_S3;
      ST_S3: if (RDY) state_d = ST_S4;
      ST_S4: begin
        if (RDY) begin
          state_d  = ST_S5;
          vec_lo_d = lock_vec;
          nmi_clr  = (lock_vec == VEC_LO_NMI);
        end
      end
      ST_S5: if (RDY) state_d = ST_S6;
      ST_S6: begin
        if (RDY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (src_q == SRC_RES) res_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge in the same cycle as the clear keeps the latch set.
    if (nmi_fall)     nmi_pend_d = 1'b1;
    else if (nmi_clr) nmi_pend_d = 1'b0;
    else              nmi_pend_d = nmi_pend_q;
  end

  // Outputs: strobes gated by RDY, everything quiet while idle.
  always_comb begin
    BUSY     = busy;
    STEP     = busy ? state_q : 3'd0;
    PUSH     = 1'b0;
    PUSH_SEL = 2'd0;
    B_OUT    = busy && (src_q == SRC_BRK);
    SET_I    = 1'b0;
    VEC_RD   = 1'b0;
    VEC_ADDR = 16'h0000;
    NMI_PEND = nmi_pend_q;
    DONE     = done_q;

    case (state_q)
      ST_S2: begin
        PUSH_SEL = 2'd0;
        PUSH     = RDY && (src_q != SRC_RES);
      end
      ST_S3: begin
        PUSH_SEL = 2'd1;
        PUSH     = RDY && (src_q != SRC_RES);
      end
      ST_S4: begin
        PUSH_SEL = 2'd2;
        PUSH     = RDY && (src_q != SRC_RES);
        SET_I    = RDY;
      end
      ST_S5: begin
        VEC_RD   = RDY;
        VEC_ADDR = {VEC_HI, vec_lo_q};
      end
      ST_S6: begin
        VEC_RD   = RDY;
        VEC_ADDR = {VEC_HI, vec_lo_q + 8'd1};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - directed self-checking bench for irq_sched
module tb_irq_sched;

  logic        CLK = 1'b0;
  logic        n_RES, n_NMI, n_IRQ, I_FLAG, BRK, SYNC, RDY;
  logic        BUSY, PUSH, B_OUT, SET_I, VEC_RD, NMI_PEND, DONE;
  logic [2:0]  STEP;
  logic [1:0]  PUSH_SEL;
  logic [15:0] VEC_ADDR;

  int checks = 0;
  int failures = 0;

  irq_sched #(.VEC_HI(8'hFF)) dut (
    .CLK(CLK), .n_RES(n_RES), .n_NMI(n_NMI), .n_IRQ(n_IRQ), .I_FLAG(I_FLAG),
    .BRK(BRK), .SYNC(SYNC), .RDY(RDY), .BUSY(BUSY), .STEP(STEP), .PUSH(PUSH),
    .PUSH_SEL(PUSH_SEL), .B_OUT(B_OUT), .SET_I(SET_I), .VEC_RD(VEC_RD),
    .VEC_ADDR(VEC_ADDR), .NMI_PEND(NMI_PEND), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    logic [15:0] ea;
    n_RES = 1'b0; n_NMI = 1'b0; n_IRQ = 1'b1; I_FLAG = 1'b1;
    BRK = 1'b0; SYNC = 1'b1; RDY = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    checks++; if (STEP !== 3'd0) begin failures++; $display("FAIL rst_step got=%0d exp=0", STEP); end
    checks++; if ({PUSH, SET_I, VEC_RD, DONE, B_OUT, NMI_PEND} !== 6'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=000000", {PUSH, SET_I, VEC_RD, DONE, B_OUT, NMI_PEND}); end
    checks++; if (VEC_ADDR !== 16'h0000) begin failures++; $display("FAIL rst_vec got=%h exp=0000", VEC_ADDR); end
    n_RES = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge CLK);
      ea = (k == 5) ? 16'hFFFC : (k == 6) ? 16'hFFFD : 16'h0000;
      checks++; if (BUSY !== 1'b1 || STEP !== 3'(k)) begin failures++; $display("FAIL res_step k=%0d got busy=%b step=%0d", k, BUSY, STEP); end
      checks++; if (PUSH !== 1'b0) begin failures++; $display("FAIL res_push k=%0d got=%b exp=0", k, PUSH); end
      checks++; if (VEC_ADDR !== ea) begin failures++; $display("FAIL res_vec k=%0d got=%h exp=%h", k, VEC_ADDR, ea); end
      checks++; if (SET_I !== (k == 4) || VEC_RD !== (k >= 5)) begin failures++; $display("FAIL res_strb k=%0d got set_i=%b vec_rd=%b", k, SET_I, VEC_RD); end
      checks++; if (NMI_PEND !== 1'b0) begin failures++; $display("FAIL res_nmi_held k=%0d got=%b exp=0", k, NMI_PEND); end
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL res_done got done=%b busy=%b exp 1 0", DONE, BUSY); end
    SYNC = 1'b0; n_NMI = 1'b1;
    @(negedge CLK);
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL res_done_pulse got done=%b busy=%b exp 0 0", DONE, BUSY); end
  endtask

  task automatic test_irq_mask();
    logic [15:0] ea;
    logic [1:0]  es;
    n_IRQ = 1'b0; I_FLAG = 1'b1; SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL irq_masked got busy=%b exp=0", BUSY); end
    I_FLAG = 1'b0; SYNC = 1'b1;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b1 || STEP !== 3'd0) begin failures++; $display("FAIL irq_start got busy=%b step=%0d", BUSY, STEP); end
    SYNC = 1'b0; n_IRQ = 1'b1; I_FLAG = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      ea = (k == 5) ? 16'hFFFE : (k == 6) ? 16'hFFFF : 16'h0000;
      es = (k >= 2 && k <= 4) ? 2'(k - 2) : 2'd0;
      checks++; if (STEP !== 3'(k)) begin failures++; $display("FAIL irq_step got=%0d exp=%0d", STEP, k); end
      checks++; if (PUSH !== (k >= 2 && k <= 4) || PUSH_SEL !== es) begin failures++; $display("FAIL irq_push k=%0d got push=%b sel=%0d exp sel=%0d", k, PUSH, PUSH_SEL, es); end
      checks++; if (B_OUT !== 1'b0) begin failures++; $display("FAIL irq_bout k=%0d got=%b exp=0", k, B_OUT); end
      checks++; if (VEC_ADDR !== ea) begin failures++; $display("FAIL irq_vec k=%0d got=%h exp=%h", k, VEC_ADDR, ea); end
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL irq_done got=%b exp=1", DONE); end
  endtask

  task automatic test_nmi_hijack();
    BRK = 1'b1; SYNC = 1'b1;
    @(negedge CLK);
    checks++; if (STEP !== 3'd0 || BUSY !== 1'b1) begin failures++; $display("FAIL hij_start got busy=%b step=%0d", BUSY, STEP); end
    BRK = 1'b0; SYNC = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (STEP !== 3'd3 || NMI_PEND !== 1'b0) begin failures++; $display("FAIL hij_s3 got step=%0d nmi=%b", STEP, NMI_PEND); end
    n_NMI = 1'b0;
    @(negedge CLK);
    checks++; if (NMI_PEND !== 1'b1) begin failures++; $display("FAIL hij_latch got=%b exp=1", NMI_PEND); end
    checks++; if (PUSH !== 1'b1 || PUSH_SEL !== 2'd2 || B_OUT !== 1'b1 || SET_I !== 1'b1) begin failures++; $display("FAIL hij_p got push=%b sel=%0d b=%b seti=%b", PUSH, PUSH_SEL, B_OUT, SET_I); end
    @(negedge CLK);
    checks++; if (VEC_ADDR !== 16'hFFFA || NMI_PEND !== 1'b0) begin failures++; $display("FAIL hij_s5 got vec=%h nmi=%b exp FFFA 0", VEC_ADDR, NMI_PEND); end
    n_NMI = 1'b1;
    @(negedge CLK);
    checks++; if (VEC_ADDR !== 16'hFFFB || B_OUT !== 1'b1) begin failures++; $display("FAIL hij_s6 got vec=%h b=%b exp FFFB 1", VEC_ADDR, B_OUT); end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1 || NMI_PEND !== 1'b0) begin failures++; $display("FAIL hij_done got done=%b nmi=%b", DONE, NMI_PEND); end
  endtask

  task automatic test_priority();
    n_NMI = 1'b0;
    @(negedge CLK);
    checks++; if (NMI_PEND !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL pri_latch got nmi=%b busy=%b", NMI_PEND, BUSY); end
    BRK = 1'b1; n_IRQ = 1'b0; I_FLAG = 1'b0; SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0; n_NMI = 1'b1;
    checks++; if (BUSY !== 1'b1 || B_OUT !== 1'b0) begin failures++; $display("FAIL pri_nmi_start got busy=%b b=%b exp 1 0", BUSY, B_OUT); end
    repeat (5) @(negedge CLK);
    checks++; if (STEP !== 3'd5 || VEC_ADDR !== 16'hFFFA || NMI_PEND !== 1'b0) begin failures++; $display("FAIL pri_nmi_vec got step=%0d vec=%h nmi=%b", STEP, VEC_ADDR, NMI_PEND); end
    repeat (2) @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL pri_nmi_done got=%b exp=1", DONE); end
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0; BRK = 1'b0; n_IRQ = 1'b1; I_FLAG = 1'b1;
    checks++; if (BUSY !== 1'b1 || B_OUT !== 1'b1) begin failures++; $display("FAIL pri_brk_start got busy=%b b=%b exp 1 1", BUSY, B_OUT); end
    repeat (5) @(negedge CLK);
    checks++; if (VEC_ADDR !== 16'hFFFE) begin failures++; $display("FAIL pri_brk_vec got=%h exp=FFFE", VEC_ADDR); end
    repeat (2) @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL pri_brk_done got=%b exp=1", DONE); end
  endtask

  task automatic test_stall();
    int pcl;
    pcl = 0;
    n_IRQ = 1'b0; I_FLAG = 1'b0; SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0; n_IRQ = 1'b1; I_FLAG = 1'b1;
    repeat (3) @(negedge CLK);
    RDY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (STEP !== 3'd3 || PUSH !== 1'b0) begin failures++; $display("FAIL stall c=%0d got step=%0d push=%b exp 3 0", c, STEP, PUSH); end
      if (c < 2) @(negedge CLK);
    end
    @(negedge CLK);
    RDY = 1'b1;
    #1;
    if (PUSH === 1'b1 && PUSH_SEL === 2'd1) pcl++;
    checks++; if (STEP !== 3'd3) begin failures++; $display("FAIL stall_hold got step=%0d exp=3", STEP); end
    @(negedge CLK);
    if (PUSH === 1'b1 && PUSH_SEL === 2'd1) pcl++;
    checks++; if (STEP !== 3'd4 || PUSH_SEL !== 2'd2) begin failures++; $display("FAIL stall_adv got step=%0d sel=%0d exp 4 2", STEP, PUSH_SEL); end
    checks++; if (pcl !== 1) begin failures++; $display("FAIL stall_pcl got=%0d exp=1", pcl); end
    repeat (3) @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", DONE); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] ea;
    n_IRQ = 1'b0; I_FLAG = 1'b0; SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0; n_IRQ = 1'b1; I_FLAG = 1'b1;
    repeat (5) @(negedge CLK);
    checks++; if (STEP !== 3'd5 || VEC_RD !== 1'b1) begin failures++; $display("FAIL mid_s5 got step=%0d vrd=%b", STEP, VEC_RD); end
    n_RES = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b0 || STEP !== 3'd0 || VEC_RD !== 1'b0 || VEC_ADDR !== 16'h0000) begin failures++; $display("FAIL mid_abort got busy=%b step=%0d vrd=%b vec=%h", BUSY, STEP, VEC_RD, VEC_ADDR); end
    SYNC = 1'b1;
    @(negedge CLK);
    n_RES = 1'b1;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b1 || STEP !== 3'd0) begin failures++; $display("FAIL mid_restart got busy=%b step=%0d", BUSY, STEP); end
    SYNC = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      ea = (k == 5) ? 16'hFFFC : (k == 6) ? 16'hFFFD : 16'h0000;
      checks++; if (PUSH !== 1'b0 || VEC_ADDR !== ea) begin failures++; $display("FAIL mid_res k=%0d got push=%b vec=%h exp vec=%h", k, PUSH, VEC_ADDR, ea); end
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL mid_done got=%b exp=1", DONE); end
  endtask

  initial begin
    test_reset();
    test_irq_mask();
    test_nmi_hijack();
    test_priority();
    test_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
